// File: rtl/nxn_game_core_if.sv
// nxn_game_core_if: move-request handshake between a move source (master) and the game core (slave).
// The move is taken on a cycle where move_valid and move_ready are both high; move_err flags a rejected move.
interface nxn_game_core_if #(
    parameter int CW = 2
);
    logic          move_valid;
    logic [CW-1:0] move_row;
    logic [CW-1:0] move_col;
    logic          move_ready;
    logic          move_err;

    modport master (output move_valid, move_row, move_col, input  move_ready, move_err);
    modport slave  (input  move_valid, move_row, move_col, output move_ready, move_err);
endinterface

// File: rtl/nxn_game_core.sv
// nxn_game_core: N x N, K-in-a-row two-player engine with a per-turn BCD countdown and a sequential win scan.
// Optional macro TIMEOUT_LOSS_EN: a turn timeout ends the game in favour of the opponent.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, waiting for start_game low
// S_PLAY  | accepting moves, per-turn timer running on tick_1hz
// S_CHECK | scanning lines through the last placed cell, one cell/cycle
// S_END   | game over, board and time-left frozen, waiting for restart
module nxn_game_core #(
    parameter  int BOARD_N   = 3,
    parameter  int WIN_LEN   = 3,
    parameter  int TURN_TIME = 30,
    localparam int CW        = $clog2(BOARD_N)
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_start_game,
    input  logic            i_tick_1hz,
    nxn_game_core_if.slave  mv,
    input  logic [CW-1:0]   i_rd_row,
    input  logic [CW-1:0]   i_rd_col,
    output logic [1:0]      o_rd_data,
    output logic            o_start,
    output logic            o_turn,
    output logic [1:0]      o_game_end,
    output logic [3:0]      o_time_left_ten,
    output logic [3:0]      o_time_left_one
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_CHECK, S_END} state_t;

    localparam int CW1 = CW + 1;
    localparam int PW  = CW + 2;
    localparam int MCW = $clog2(BOARD_N * BOARD_N + 1);

    localparam logic [CW1-1:0]       N_U    = CW1'(BOARD_N);
    localparam logic signed [PW-1:0] S_N    = PW'(BOARD_N);
    localparam logic signed [PW-1:0] S_ONE  = PW'(1);
    localparam logic signed [PW-1:0] S_ZERO = '0;
    localparam logic signed [PW-1:0] S_NEG  = -S_ONE;
    localparam logic [MCW-1:0]       CELLS  = MCW'(BOARD_N * BOARD_N);
    localparam logic [3:0]           WL     = 4'(WIN_LEN);
    localparam logic [3:0]           TT_TEN = 4'(TURN_TIME / 10);
    localparam logic [3:0]           TT_ONE = 4'(TURN_TIME % 10);

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_board [BOARD_N][BOARD_N];
    logic                 r_turn, w_turn_nxt;
    logic [1:0]           r_game_end, w_end_nxt;
    logic [3:0]           r_ten, r_one, w_ten_nxt, w_one_nxt;
    logic                 r_err, w_err_nxt;
    logic [CW-1:0]        r_row, r_col, w_row_nxt, w_col_nxt;
    logic signed [PW-1:0] r_pr, r_pc, w_pr_nxt, w_pc_nxt;
    logic [1:0]           r_dir, w_dir_nxt;
    logic                 r_side, w_side_nxt;
    logic [3:0]           r_cnt, w_cnt_nxt;
    logic [MCW-1:0]       r_mcnt, w_mcnt_nxt;

    logic                 w_clr, w_wr;
    logic [1:0]           w_mover;
    logic                 w_mv_in, w_mv_legal;
    logic signed [PW-1:0] w_dr, w_dc, w_nr, w_nc, w_or, w_oc;
    logic                 w_n_in, w_n_match;
    logic                 w_time_one;

    assign w_mover    = r_turn ? 2'b10 : 2'b01;
    assign w_mv_in    = ({1'b0, mv.move_row} < N_U) && ({1'b0, mv.move_col} < N_U);
    assign w_mv_legal = w_mv_in && (r_board[mv.move_row][mv.move_col] == 2'b00);
    assign w_time_one = (r_ten == 4'd0) && (r_one == 4'd1);
    assign w_or       = $signed({2'b00, r_row});
    assign w_oc       = $signed({2'b00, r_col});

    // Direction order H, V, D, A; the negative side walks the same vector backwards.
    always_comb begin
        w_dr = S_ONE;
        w_dc = S_ONE;
        case (r_dir)
            2'd0:    w_dr = S_ZERO;
            2'd1:    w_dc = S_ZERO;
            2'd2:    ;
            default: w_dc = S_NEG;
        endcase
    end

    assign w_nr      = r_side ? (r_pr - w_dr) : (r_pr + w_dr);
    assign w_nc      = r_side ? (r_pc - w_dc) : (r_pc + w_dc);
    assign w_n_in    = !w_nr[PW-1] && (w_nr < S_N) && !w_nc[PW-1] && (w_nc < S_N);
    assign w_n_match = w_n_in && (r_board[w_nr[CW-1:0]][w_nc[CW-1:0]] == w_mover);

    always_comb begin
        w_state_nxt = r_state;
        w_turn_nxt  = r_turn;
        w_end_nxt   = r_game_end;
        w_ten_nxt   = r_ten;
        w_one_nxt   = r_one;
        w_err_nxt   = 1'b0;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_pr_nxt    = r_pr;
        w_pc_nxt    = r_pc;
        w_dir_nxt   = r_dir;
        w_side_nxt  = r_side;
        w_cnt_nxt   = r_cnt;
        w_mcnt_nxt  = r_mcnt;
        w_clr       = 1'b0;
        w_wr        = 1'b0;
        case (r_state)
            S_IDLE, S_END: begin
                if (!i_start_game) begin
                    w_clr       = 1'b1;
                    w_mcnt_nxt  = '0;
                    w_turn_nxt  = 1'b0;
                    w_end_nxt   = 2'b00;
                    w_ten_nxt   = TT_TEN;
                    w_one_nxt   = TT_ONE;
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                // Any handshake, legal or not, swallows a coincident tick.
                if (mv.move_valid) begin
                    if (w_mv_legal) begin
                        w_wr        = 1'b1;
                        w_row_nxt   = mv.move_row;
                        w_col_nxt   = mv.move_col;
                        w_pr_nxt    = $signed({2'b00, mv.move_row});
                        w_pc_nxt    = $signed({2'b00, mv.move_col});
                        w_mcnt_nxt  = r_mcnt + 1'b1;
                        w_dir_nxt   = 2'd0;
                        w_side_nxt  = 1'b0;
                        w_cnt_nxt   = 4'd1;
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (i_tick_1hz) begin
                    if (w_time_one) begin
`ifdef TIMEOUT_LOSS_EN
                        w_end_nxt   = r_turn ? 2'b01 : 2'b10;
                        w_ten_nxt   = 4'd0;
                        w_one_nxt   = 4'd0;
                        w_state_nxt = S_END;
`else
                        w_turn_nxt  = ~r_turn;
                        w_ten_nxt   = TT_TEN;
                        w_one_nxt   = TT_ONE;
`endif
                    end else if (r_one == 4'd0) begin
                        w_one_nxt = 4'd9;
                        w_ten_nxt = r_ten - 4'd1;
                    end else begin
                        w_one_nxt = r_one - 4'd1;
                    end
                end
            end
            S_CHECK: begin
                if (w_n_match) begin
                    if (r_cnt + 4'd1 == WL) begin
                        w_end_nxt   = w_mover;
                        w_state_nxt = S_END;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                        w_pr_nxt  = w_nr;
                        w_pc_nxt  = w_nc;
                    end
                end else if (!r_side) begin
                    w_side_nxt = 1'b1;
                    w_pr_nxt   = w_or;
                    w_pc_nxt   = w_oc;
                end else if (r_dir != 2'd3) begin
                    w_dir_nxt  = r_dir + 2'd1;
                    w_side_nxt = 1'b0;
                    w_cnt_nxt  = 4'd1;
                    w_pr_nxt   = w_or;
                    w_pc_nxt   = w_oc;
                end else if (r_mcnt == CELLS) begin
                    w_end_nxt   = 2'b11;
                    w_state_nxt = S_END;
                end else begin
                    w_turn_nxt  = ~r_turn;
                    w_ten_nxt   = TT_TEN;
                    w_one_nxt   = TT_ONE;
                    w_state_nxt = S_PLAY;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_turn     <= 1'b0;
            r_game_end <= 2'b00;
            r_ten      <= TT_TEN;
            r_one      <= TT_ONE;
            r_err      <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_pr       <= '0;
            r_pc       <= '0;
            r_dir      <= 2'd0;
            r_side     <= 1'b0;
            r_cnt      <= 4'd0;
            r_mcnt     <= '0;
        end else begin
            r_turn     <= w_turn_nxt;
            r_game_end <= w_end_nxt;
            r_ten      <= w_ten_nxt;
            r_one      <= w_one_nxt;
            r_err      <= w_err_nxt;
            r_row      <= w_row_nxt;
            r_col      <= w_col_nxt;
            r_pr       <= w_pr_nxt;
            r_pc       <= w_pc_nxt;
            r_dir      <= w_dir_nxt;
            r_side     <= w_side_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mcnt     <= w_mcnt_nxt;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < BOARD_N; i++) begin
                for (int j = 0; j < BOARD_N; j++) begin
                    r_board[i][j] <= 2'b00;
                end
            end
        end else if (w_clr) begin
            for (int i = 0; i < BOARD_N; i++) begin
                for (int j = 0; j < BOARD_N; j++) begin
                    r_board[i][j] <= 2'b00;
                end
            end
        end else if (w_wr) begin
            r_board[mv.move_row][mv.move_col] <= w_mover;
        end
    end

    always_comb begin
        o_rd_data = 2'b00;
        if (({1'b0, i_rd_row} < N_U) && ({1'b0, i_rd_col} < N_U)) begin
            o_rd_data = r_board[i_rd_row][i_rd_col];
        end
    end

    assign mv.move_ready   = (r_state == S_PLAY);
    assign mv.move_err     = r_err;
    assign o_start         = (r_state == S_PLAY) || (r_state == S_CHECK);
    assign o_turn          = r_turn;
    assign o_game_end      = r_game_end;
    assign o_time_left_ten = r_ten;
    assign o_time_left_one = r_one;

endmodule
